restriction_tt_sweeper: RTL
===========================

Name: restriction_tt_sweeper

Overview:
- Sequential harness stage wrapped around one combinational restriction function (6 inputs x0..x5, single output y0).
- Upstream, it drives every input vector into the function in ascending order. Downstream, it captures y0 for each vector into a 2^N_IN-bit truth table.
- Compares the captured table against a golden table and reports pass/fail, mismatch count and first failing vector.
- Used to check each mockturtle-optimised restriction netlist against its source PLA on-chip or in simulation.

Parameters:
- N_IN, 6, number of function inputs; truth-table width is TT_W = 2^N_IN.
- SETTLE, 1, idle cycles between driving a vector and sampling y_in. Legal range 0..15; 0 means sample in the same cycle the vector is driven.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin sweep; honoured only in IDLE or DONE.
- abort  in  1  cancel a running sweep.
- golden_tt  in  TT_W  expected table; bit i is f(x=i). Latched on accepted start.
- x  out  N_IN  vector driven to the function; x[0] connects to x0.
- y_in  in  1  function output y0, sampled combinationally.
- busy  out  1  high while sweeping.
- done  out  1  high while in DONE.
- pass  out  1  done AND mismatch_cnt==0.
- tt_out  out  TT_W  captured truth table.
- mismatch_cnt  out  N_IN+1  number of vectors where y_in != golden bit.
- first_mis  out  N_IN  index of the lowest mismatching vector.
- first_mis_vld  out  1  first_mis holds a valid index.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. x=0, busy=0, done=0, pass=0, tt_out=0, mismatch_cnt=0, first_mis=0, first_mis_vld=0. Reset overrides start and abort, including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 (and abort=0):
  - Latch golden_tt; clear tt_out, mismatch_cnt and first_mis_vld; set idx=0 and x=0.
  - Next state is SETTLE with wait counter=SETTLE-1, or SAMPLE if SETTLE=0.
  - busy=1 and done=0 from the next cycle.
- SETTLE: x holds idx. When the counter reaches 0, go to SAMPLE; otherwise decrement.
- SAMPLE: x holds idx. At the clock edge:
  - Set tt_out[idx]=y_in.
  - If y_in != golden[idx]: mismatch_cnt+=1. If first_mis_vld=0, set first_mis=idx and first_mis_vld=1.
  - If idx==TT_W-1: go to DONE.
  - Otherwise: idx+=1, x=idx+1, re-arm the counter, go to SETTLE (or stay in SAMPLE when SETTLE=0).
- Cycle counts:
  - Each vector occupies SETTLE+1 cycles.
  - With start accepted at edge t, done rises at edge t+TT_W*(SETTLE+1). Default: t+128.
- DONE: busy=0 and done=1. All results hold; x holds TT_W-1. Stays in DONE until start, abort or reset.
- abort=1 in SETTLE or SAMPLE: next state IDLE, x=0, busy=0, done=0. Partial tt_out and mismatch_cnt are kept but are invalid (pass=0).
- abort=1 in DONE: go to IDLE and clear done and pass.
- abort has priority over start in the same cycle. abort in IDLE has no effect.
- start while busy is ignored. golden_tt is not re-latched during a sweep.
- mismatch_cnt cannot wrap: its maximum is TT_W, which fits in N_IN+1 bits.
- idx never exceeds TT_W-1. There is no wrap to 0 within a sweep.
- All outputs are registered except pass, which is combinational from done and mismatch_cnt.

Test Plan:
- Bench model y_in=^x and golden_tt=64'h6996966996696996, start pulse at t -> done at t+128, pass=1, mismatch_cnt=0, tt_out=golden, first_mis_vld=0.
- Same model with golden_tt inverted -> mismatch_cnt=64, first_mis=0, first_mis_vld=1, pass=0.
- Golden with bit 37 flipped -> mismatch_cnt=1, first_mis=37, pass=0. With SETTLE=0 the same result arrives at t+64; x steps every cycle.
- abort asserted while x=10 -> next cycle IDLE, busy=0, done=0, x=0. A later start re-sweeps cleanly and passes.
- start re-pulsed at x=20 -> ignored, done still at t+128. rst_n=0 at x=30 -> next cycle all outputs 0. Reset and abort asserted together with start -> remains IDLE.
- Model stuck-at-1 (y_in=1) with golden=parity -> mismatch_cnt=32, first_mis=0, tt_out=all ones.

Source files
------------

// File: rtl/restriction_tt_sweeper.sv
// Sweeps all 2^N_IN input vectors through an external combinational function,
// captures its truth table and compares it against a latched golden table.
//
// state  | meaning
// IDLE   | waiting for start, x parked at 0
// SETTLE | vector on x, counting down settle cycles before sampling
// SAMPLE | capture y_in for the current vector, then advance
// DONE   | results valid and held, x parked at last vector
module restriction_tt_sweeper #(
    parameter int N_IN   = 6,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [(1<<N_IN)-1:0]    golden_tt,
    output logic [N_IN-1:0]         x,
    input  logic                    y_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(1<<N_IN)-1:0]    tt_out,
    output logic [N_IN:0]           mismatch_cnt,
    output logic [N_IN-1:0]         first_mis,
    output logic                    first_mis_vld
);

    localparam int TT_W = 1 << N_IN;
    localparam int RELOAD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0] CNT_RELOAD = RELOAD_I[3:0];
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0] CNT_ONE = {{N_IN{1'b0}}, 1'b1};

    if (SETTLE < 0 || SETTLE > 15) begin : g_settle_range
        $error("SETTLE must be within 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // With no settle time each vector is sampled in the cycle it is driven.
    localparam state_t ARM_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TT_W-1:0]   golden_q, golden_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [N_IN:0]     mis_q, mis_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              first_vld_q, first_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        golden_d    = golden_q;
        tt_d        = tt_q;
        mis_d       = mis_q;
        first_d     = first_q;
        first_vld_d = first_vld_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (start) begin
                    golden_d    = golden_tt;
                    tt_d        = '0;
                    mis_d       = '0;
                    first_vld_d = 1'b0;
                    idx_d       = '0;
                    cnt_d       = CNT_RELOAD;
                    state_d     = ARM_STATE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    tt_d[idx_q] = y_in;
                    if (y_in != golden_q[idx_q]) begin
                        mis_d = mis_q + CNT_ONE;
                        if (!first_vld_q) begin
                            first_d     = idx_q;
                            first_vld_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        cnt_d   = CNT_RELOAD;
                        state_d = ARM_STATE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            golden_q    <= '0;
            tt_q        <= '0;
            mis_q       <= '0;
            first_q     <= '0;
            first_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            golden_q    <= golden_d;
            tt_q        <= tt_d;
            mis_q       <= mis_d;
            first_q     <= first_d;
            first_vld_q <= first_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x             = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign tt_out        = tt_q;
    assign mismatch_cnt  = mis_q;
    assign first_mis     = first_q;
    assign first_mis_vld = first_vld_q;
    assign pass          = done_q && (mis_q == '0);

endmodule
